// File: rtl/brownout_pkg.sv
// Shared types and default constants for the brownout deglitch path.
package brownout_pkg;

    // Default integrator width and hysteresis thresholds
    localparam int unsigned BROUT_CNT_W      = 4;
    localparam int unsigned BROUT_SET_TH_DEF = 12;
    localparam int unsigned BROUT_CLR_TH_DEF = 3;

    // Filtered-level state: brout_filt is high only in TRIPPED
    typedef enum logic {
        CLEAR   = 1'b0,
        TRIPPED = 1'b1
    } brout_state_e;

endpackage : brownout_pkg

// File: rtl/brownout_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
// Used for the brownout comparator and reusable for the dcomp input path.
module brownout_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : brownout_sync2

// File: rtl/brownout_filt.sv
// Brownout comparator deglitch: synchronise, integrate with a saturating
// up/down counter, apply set/clear hysteresis, and count trip events.
module brownout_filt
    import brownout_pkg::*;
#(
    parameter int unsigned CNT_W  = BROUT_CNT_W,
    parameter int unsigned SET_TH = BROUT_SET_TH_DEF,
    parameter int unsigned CLR_TH = BROUT_CLR_TH_DEF,
    parameter int unsigned EVT_W  = 8
) (
    input  logic             osc_ck,
    input  logic             rsb,
    input  logic             ena,
    input  logic             brout_raw,
    input  logic             filt_bypass,
    input  logic             evt_clr,
    output logic             brout_filt,
    output logic             brout_sync,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             evt_sticky
);

    // Thresholds must leave a hysteresis gap and be reachable by the counter
    if ((CLR_TH >= SET_TH) || (SET_TH > ((2 ** CNT_W) - 1))) begin : g_bad_th
        $fatal(1, "brownout_filt: need CLR_TH < SET_TH <= 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] SET_TH_C = CNT_W'(SET_TH);
    localparam logic [CNT_W-1:0] CLR_TH_C = CNT_W'(CLR_TH);
    localparam logic [EVT_W-1:0] EVT_MAX  = '1;
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

    logic             sync_lvl;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    brout_state_e     state_q;
    logic             filt_q;
    logic             set_cond;
    logic             clr_cond;
    logic             rise;
    logic [EVT_W-1:0] evt_cnt_q;
    logic             evt_sticky_q;

    brownout_sync2 u_sync (
        .clk_i  (osc_ck),
        .rst_ni (rsb),
        .d_i    (brout_raw),
        .q_o    (sync_lvl)
    );

    // Saturating up/down integrator; disabled block forces it back to zero
    always_comb begin
        acc_d = acc_q;
        if (!ena) begin
            acc_d = '0;
        end else if (sync_lvl && (acc_q != ACC_MAX)) begin
            acc_d = acc_q + 1'b1;
        end else if (!sync_lvl && (acc_q != '0)) begin
            acc_d = acc_q - 1'b1;
        end
    end

    // Trip/clear decisions look at the integrator value loaded on this edge;
    // in bypass the synchronised level drives the state directly
    always_comb begin
        set_cond = filt_bypass ? sync_lvl  : (acc_d >= SET_TH_C);
        clr_cond = filt_bypass ? !sync_lvl : (acc_d <= CLR_TH_C);
    end

    // A CLEAR->TRIPPED transition is what gets logged as an event
    assign rise = ena && (state_q == CLEAR) && set_cond;

    // Integrator register
    always_ff @(posedge osc_ck or negedge rsb) begin
        if (!rsb) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Hysteresis FSM with registered filtered output
    always_ff @(posedge osc_ck or negedge rsb) begin
        if (!rsb) begin
            state_q <= CLEAR;
            filt_q  <= 1'b0;
        end else if (!ena) begin
            state_q <= CLEAR;
            filt_q  <= 1'b0;
        end else if (state_q == CLEAR) begin
            if (set_cond) begin
                state_q <= TRIPPED;
                filt_q  <= 1'b1;
            end
        end else begin
            if (clr_cond) begin
                state_q <= CLEAR;
                filt_q  <= 1'b0;
            end
        end
    end

    // Event counter and sticky flag; a trip on the clearing edge still counts
    always_ff @(posedge osc_ck or negedge rsb) begin
        if (!rsb) begin
            evt_cnt_q    <= '0;
            evt_sticky_q <= 1'b0;
        end else if (rise) begin
            evt_sticky_q <= 1'b1;
            if (evt_clr) begin
                evt_cnt_q <= EVT_ONE;
            end else if (evt_cnt_q != EVT_MAX) begin
                evt_cnt_q <= evt_cnt_q + 1'b1;
            end
        end else if (evt_clr) begin
            evt_cnt_q    <= '0;
            evt_sticky_q <= 1'b0;
        end
    end

    assign brout_filt = filt_q;
    assign brout_sync = sync_lvl;
    assign evt_cnt    = evt_cnt_q;
    assign evt_sticky = evt_sticky_q;

endmodule : brownout_filt

// File: tb/tb_brownout_filt.sv
// Bench for brownout_filt: directed scenarios plus randomized traffic,
// every edge compared against an integer-level behavioural model.
module tb_brownout_filt;

    localparam int SET_TH  = 12;
    localparam int CLR_TH  = 3;
    localparam int ACC_TOP = 15;
    localparam int EVT_TOP = 255;

    logic       osc_ck;
    logic       rsb;
    logic       ena;
    logic       brout_raw;
    logic       filt_bypass;
    logic       evt_clr;
    logic       brout_filt;
    logic       brout_sync;
    logic [7:0] evt_cnt;
    logic       evt_sticky;

    int checks = 0;
    int errors = 0;

    // Behavioural model: two-deep delay line, clamped integer integrator,
    // tripped flag with hysteresis, event tally
    int m_d1, m_d2, m_acc, m_trip, m_cnt, m_sticky;

    brownout_filt #(
        .CNT_W  (4),
        .SET_TH (SET_TH),
        .CLR_TH (CLR_TH),
        .EVT_W  (8)
    ) dut (
        .osc_ck      (osc_ck),
        .rsb         (rsb),
        .ena         (ena),
        .brout_raw   (brout_raw),
        .filt_bypass (filt_bypass),
        .evt_clr     (evt_clr),
        .brout_filt  (brout_filt),
        .brout_sync  (brout_sync),
        .evt_cnt     (evt_cnt),
        .evt_sticky  (evt_sticky)
    );

    initial osc_ck = 1'b0;
    always #5 osc_ck = ~osc_ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_acc = 0; m_trip = 0; m_cnt = 0; m_sticky = 0;
    endtask

    task automatic model_edge();
        int seen;
        int nxt;
        if (!rsb) begin
            model_reset();
            return;
        end
        seen = m_d2;
        m_d2 = m_d1;
        m_d1 = int'(brout_raw);
        if (!ena) begin
            m_acc = 0;
            nxt   = 0;
        end else begin
            if (seen == 1) m_acc = (m_acc < ACC_TOP) ? m_acc + 1 : ACC_TOP;
            else           m_acc = (m_acc > 0) ? m_acc - 1 : 0;
            if (filt_bypass)     nxt = seen;
            else if (m_trip == 1) nxt = (m_acc <= CLR_TH) ? 0 : 1;
            else                 nxt = (m_acc >= SET_TH) ? 1 : 0;
        end
        if (m_trip == 0 && nxt == 1) begin
            m_cnt    = evt_clr ? 1 : ((m_cnt < EVT_TOP) ? m_cnt + 1 : EVT_TOP);
            m_sticky = 1;
        end else if (evt_clr) begin
            m_cnt    = 0;
            m_sticky = 0;
        end
        m_trip = nxt;
    endtask

    task automatic tick();
        @(posedge osc_ck);
        model_edge();
        #2;
        chk("brout_filt", brout_filt, m_trip);
        chk("brout_sync", brout_sync, m_d2);
        chk("evt_cnt",    evt_cnt,    m_cnt);
        chk("evt_sticky", evt_sticky, m_sticky);
    endtask

    // Count edges until brout_filt reaches val; -1 if the budget runs out
    task automatic edges_until(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (brout_filt === val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int seen_hi;
        int run;

        model_reset();
        rsb = 1'b0; ena = 1'b1; brout_raw = 1'b1; filt_bypass = 1'b0; evt_clr = 1'b0;

        // Reset held with raw high: everything stays zero
        repeat (3) tick();
        chk("reset_filt",   brout_filt, 0);
        chk("reset_sync",   brout_sync, 0);
        chk("reset_cnt",    evt_cnt,    0);
        chk("reset_sticky", evt_sticky, 0);

        // Release: trips on edge 2+SET_TH
        rsb = 1'b1;
        edges_until(1'b1, 40, n);
        chk("first_trip_edge", n, 2 + SET_TH);
        chk("first_trip_cnt", evt_cnt, 1);
        chk("first_trip_sticky", evt_sticky, 1);

        // Drain to zero, then an 11-cycle glitch must not trip
        brout_raw = 1'b0;
        repeat (25) tick();
        brout_raw = 1'b1;
        seen_hi = 0;
        repeat (11) begin tick(); if (brout_filt !== 1'b0) seen_hi = 1; end
        brout_raw = 1'b0;
        repeat (20) begin tick(); if (brout_filt !== 1'b0) seen_hi = 1; end
        chk("glitch_no_trip", seen_hi, 0);
        chk("glitch_cnt", evt_cnt, 1);

        // Saturate, then fall takes 2+(15-CLR_TH) edges
        brout_raw = 1'b1;
        repeat (30) tick();
        chk("sat_trip_cnt", evt_cnt, 2);
        brout_raw = 1'b0;
        edges_until(1'b0, 40, n);
        chk("fall_edge", n, 2 + (ACC_TOP - CLR_TH));

        // Rising again: from integrator value 5, seven increments re-trip
        brout_raw = 1'b1;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_acc == 5 && m_d2 == 1) begin n = i; break; end
        end
        chk("reach_acc5", (n >= 0), 1);
        edges_until(1'b1, 20, n);
        chk("retrip_incr", n, SET_TH - 5);
        chk("retrip_cnt", evt_cnt, 3);

        // Bypass mode
        brout_raw = 1'b0;
        filt_bypass = 1'b1;
        repeat (20) tick();
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        chk("clr_alone_cnt", evt_cnt, 0);
        chk("clr_alone_sticky", evt_sticky, 0);

        brout_raw = 1'b1;
        tick();
        brout_raw = 1'b0;
        tick();
        chk("byp_edge2", brout_filt, 0);
        tick();
        chk("byp_edge3", brout_filt, 1);
        tick();
        chk("byp_edge4", brout_filt, 0);
        chk("byp_cnt", evt_cnt, 1);

        // Clear coinciding with a trip: the event survives
        brout_raw = 1'b1;
        tick();
        tick();
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        chk("simul_cnt", evt_cnt, 1);
        chk("simul_sticky", evt_sticky, 1);
        brout_raw = 1'b0;
        repeat (4) tick();

        // 300 bypass pulses saturate the counter
        repeat (300) begin
            brout_raw = 1'b1; tick();
            brout_raw = 1'b0; tick(); tick();
        end
        repeat (3) tick();
        chk("evt_sat", evt_cnt, EVT_TOP);

        // Enable drop while tripped and saturated
        filt_bypass = 1'b0;
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        brout_raw = 1'b1;
        repeat (30) tick();
        chk("pre_drop_filt", brout_filt, 1);
        ena = 1'b0;
        tick();
        chk("drop_filt", brout_filt, 0);
        chk("drop_cnt", evt_cnt, 1);
        ena = 1'b1;
        edges_until(1'b1, 30, n);
        chk("reena_edges", n, SET_TH);
        chk("reena_cnt", evt_cnt, 2);

        // Randomized traffic against the model
        run = 1;
        for (int i = 0; i < 800; i++) begin
            run--;
            if (run <= 0) begin
                brout_raw = ~brout_raw;
                run = int'($urandom_range(1, 20));
            end
            if ($urandom_range(0, 99) < 3) filt_bypass = ~filt_bypass;
            evt_clr = ($urandom_range(0, 99) < 2);
            ena     = ($urandom_range(0, 199) != 0);
            tick();
        end
        evt_clr = 1'b0;
        ena = 1'b1;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_brownout_filt
